// File: rtl/sb_serializer_tx.sv
// Sideband serializer: shifts a parallel word out LSB first with a gated bit clock,
// then holds the clock off for GAP cycles before the next word may start.
module sb_serializer_tx #(
  parameter int WIDTH   = 64,
  parameter int WIDTH_W = 6,
  parameter int GAP     = 32,
  parameter int GAP_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_data_valid,
  output logic             in_data_ready,
  output logic             out_data,
  output logic             out_clk_en,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  localparam logic [WIDTH_W-1:0] LAST_BIT = WIDTH_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP = GAP_W'(GAP - 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   sr, sr_n;
  logic [WIDTH_W-1:0] bcnt, bcnt_n;
  logic [GAP_W-1:0]   gcnt, gcnt_n;
  logic               od_n, en_n;
  logic               xfer;

  // Ready in the last gap cycle lets streamed words start with exactly GAP idle cycles.
  assign in_data_ready = !rst && ((state == ST_IDLE) ||
                                  ((state == ST_GAP) && (gcnt == LAST_GAP)));
  assign xfer = in_data_valid && in_data_ready;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sr         <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      out_data   <= 1'b0;
      out_clk_en <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bcnt       <= bcnt_n;
      gcnt       <= gcnt_n;
      out_data   <= od_n;
      out_clk_en <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    od_n    = out_data;
    en_n    = out_clk_en;
    case (state)
      ST_SHIFT: begin
        if (bcnt == LAST_BIT) begin
          od_n    = 1'b0;
          en_n    = 1'b0;
          gcnt_n  = '0;
          state_n = ST_GAP;
        end else begin
          od_n   = sr[0];
          sr_n   = sr >> 1;
          bcnt_n = bcnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt == LAST_GAP) state_n = ST_IDLE;
        else                  gcnt_n  = gcnt + 1'b1;
      end
      default: ;
    endcase
    // A transfer can only happen in IDLE or the last gap cycle; it overrides both.
    if (xfer) begin
      od_n    = in_data[0];
      en_n    = 1'b1;
      sr_n    = in_data >> 1;
      bcnt_n  = '0;
      state_n = ST_SHIFT;
    end
  end

endmodule

// File: doc/sb_serializer_tx.md
SB_SERIALIZER_TX -- requirements
Module: sb_serializer_tx

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the parallel word width in bits.
REQ-002 Parameter WIDTH_W, default 6, SHALL set the bit-counter width; it SHALL hold WIDTH-1.
REQ-003 Parameter GAP, default 32, SHALL set the idle cycles (clock gated) between packets; GAP >= 1.
REQ-004 Parameter GAP_W, default 5, SHALL set the gap-counter width; it SHALL hold GAP-1.
REQ-005 clk  input  1  SHALL be the sideband bit clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 in_data  input  WIDTH  SHALL be the parallel packet word to transmit.
REQ-008 in_data_valid  input  1  SHALL indicate in_data holds a word to send.
REQ-009 in_data_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-010 out_data  output  1  SHALL be the registered serial data bit.
REQ-011 out_clk_en  output  1  SHALL be the registered clock-gate enable; high only while a valid bit is on out_data.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, GAP.
REQ-014 in_data_ready SHALL be combinational: high in IDLE, high in GAP when gap counter == GAP-1, low otherwise, and low while rst is high.
REQ-015 A transfer SHALL occur only on a rising edge with in_data_valid && in_data_ready; in_data is ignored otherwise.
REQ-016 On transfer: out_data <= in_data[0], out_clk_en <= 1, shift register <= in_data >> 1, bit counter <= 0, state <= SHIFT.
REQ-017 In SHIFT with bit counter < WIDTH-1: out_data <= shift register[0], shift register shifts right by one, bit counter increments, out_clk_en stays 1.
REQ-018 In SHIFT with bit counter == WIDTH-1: out_data <= 0, out_clk_en <= 0, gap counter <= 0, state <= GAP.
REQ-019 Bits SHALL be sent LSB first; bit i SHALL appear on out_data in the i-th cycle after the transfer edge (i = 0..WIDTH-1); out_clk_en SHALL be high for exactly WIDTH consecutive cycles per packet.
REQ-020 In GAP: out_data and out_clk_en SHALL remain 0; the gap counter SHALL increment each cycle below GAP-1.
REQ-021 In GAP with gap counter == GAP-1: a transfer SHALL apply REQ-016 directly; without a transfer, state <= IDLE.
REQ-022 Back-to-back packets SHALL have exactly GAP low cycles of out_clk_en between them; an isolated packet SHALL have at least GAP.
REQ-023 In IDLE without a transfer, all outputs and counters SHALL hold; out_data = 0, out_clk_en = 0.
REQ-024 in_data changes while not ready SHALL have no effect on the packet in flight.
REQ-025 Bit-counter wrap SHALL never occur; it resets to 0 on each transfer.

Reset
REQ-026 While rst is high: state = IDLE, out_data = 0, out_clk_en = 0, busy = 0, in_data_ready = 0, counters = 0, shift register = 0.
REQ-027 rst asserted mid-SHIFT or mid-GAP SHALL abort immediately; the partial packet is discarded and is not resumed.
REQ-028 In the first cycle after rst deasserts: IDLE, in_data_ready = 1.

Verification
REQ-029 WIDTH=64, GAP=32; send 64'hA5A5_0000_FFFF_1234 -> out_clk_en high for 64 cycles, out_data LSB first = 0,0,1,0,1,1,0,0,... ; busy high for 96 cycles.
REQ-030 Two words held valid back-to-back -> exactly 32 cycles with out_clk_en = 0 between packets; in_data_ready pulses once per packet, in the last GAP cycle.
REQ-031 in_data_valid toggled with changing in_data during SHIFT -> transmitted bits match only the word captured at the transfer edge.
REQ-032 rst pulsed at bit 20 of a packet -> out_clk_en = 0 and out_data = 0 immediately; next word sent from bit 0 after rst release.
REQ-033 WIDTH=8, WIDTH_W=3, GAP=1, GAP_W=1; stream words 8'h81, 8'h7E -> 8 enabled cycles, 1 gated cycle, 8 enabled cycles; bits 1,0,0,0,0,0,0,1 then 0,1,1,1,1,1,1,0.
REQ-034 Loopback into the downstream deserializer, which samples on the falling edge while out_clk_en = 1 -> recovered words equal sent words for 100 random packets.
